// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: five-state floating-point add/subtract with sticky alignment, LZC normalisation and status flags.
// Macro FP_ADDSUB_ROUND_NEAREST_EN: defined = round-to-nearest-even, undefined = truncate toward zero.
module fp_addsub_unit #(
  parameter int M = 10,
  parameter int E = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic         op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [E-1:0] a_exp,
  input  logic [E-1:0] b_exp,
  input  logic         a_sign,
  input  logic         b_sign,
  output logic [M-1:0] c,
  output logic [E-1:0] c_exp,
  output logic         c_sign,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         underflow,
  output logic         inexact,
  output logic         invalid
);
  localparam int W   = M + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int XE  = E + 2;  // signed exponent with headroom for carry and borrow
  localparam int LZW = $clog2(W + 1);
  localparam logic [E-1:0]          EMAX   = '1;
  localparam logic signed [XE-1:0]  EMAX_X = {2'b00, EMAX};
  localparam logic signed [XE-1:0]  ZERO_X = '0;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state_reg, state_next;

  logic [M-1:0]         a_man_reg, b_man_reg, sp_man_reg;
  logic [E-1:0]         a_exp_reg, b_exp_reg, sp_exp_reg;
  logic                 a_sign_reg, b_sign_reg, sp_sign_reg, sp_inv_reg, special_reg;
  logic [W-1:0]         x_ext_reg, y_ext_reg, man_reg;
  logic                 sub_reg, sign_reg, zero_reg, uf_reg;
  logic signed [XE-1:0] exp_reg;
  logic [W:0]           sum_reg;

  // Alignment and special-value resolution
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [E-1:0] x_exp, y_exp, diff, sp_exp;
  logic [M-1:0] x_man, y_man, sp_man;
  logic         x_sign, y_sign, sp, sp_inv, sp_sign;
  logic [W-1:0] y_full, y_shift, lost;

  always_comb begin
    a_zero = (a_exp_reg == '0);
    b_zero = (b_exp_reg == '0);
    a_inf  = (a_exp_reg == EMAX) && (a_man_reg == '0);
    b_inf  = (b_exp_reg == EMAX) && (b_man_reg == '0);
    a_nan  = (a_exp_reg == EMAX) && (a_man_reg != '0);
    b_nan  = (b_exp_reg == EMAX) && (b_man_reg != '0);
    swap   = {b_exp_reg, b_man_reg} > {a_exp_reg, a_man_reg};
    x_exp  = swap ? b_exp_reg  : a_exp_reg;
    x_man  = swap ? b_man_reg  : a_man_reg;
    x_sign = swap ? b_sign_reg : a_sign_reg;
    y_exp  = swap ? a_exp_reg  : b_exp_reg;
    y_man  = swap ? a_man_reg  : b_man_reg;
    y_sign = swap ? a_sign_reg : b_sign_reg;
    diff   = x_exp - y_exp;
    y_full = {1'b1, y_man, 3'b000};
    lost   = '0;
    y_shift = {{(W-1){1'b0}}, 1'b1};
    if (int'(diff) < W) begin
      lost    = y_full & ~({W{1'b1}} << diff);
      y_shift = (y_full >> diff) | {{(W-1){1'b0}}, |lost};
    end

    sp      = 1'b1;
    sp_inv  = 1'b0;
    sp_sign = 1'b0;
    sp_exp  = '0;
    sp_man  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign_reg != b_sign_reg))) begin
      sp_inv = 1'b1;
      sp_exp = EMAX;
      sp_man = {1'b1, {(M-1){1'b0}}};
    end else if (a_inf) begin
      sp_sign = a_sign_reg;
      sp_exp  = EMAX;
    end else if (b_inf) begin
      sp_sign = b_sign_reg;
      sp_exp  = EMAX;
    end else if (a_zero && b_zero) begin
      sp_sign = a_sign_reg & b_sign_reg;
    end else if (a_zero) begin
      {sp_sign, sp_exp, sp_man} = {b_sign_reg, b_exp_reg, b_man_reg};
    end else if (b_zero) begin
      {sp_sign, sp_exp, sp_man} = {a_sign_reg, a_exp_reg, a_man_reg};
    end else begin
      sp = 1'b0;
    end
  end

  // Magnitude add/subtract; the larger operand is always x, so the difference is never negative
  logic [W:0] sum_next;
  always_comb begin
    sum_next = sub_reg ? ({1'b0, x_ext_reg} - {1'b0, y_ext_reg})
                       : ({1'b0, x_ext_reg} + {1'b0, y_ext_reg});
  end

  logic [LZW-1:0]       lz;
  logic [W-1:0]         norm_man;
  logic signed [XE-1:0] norm_exp;
  always_comb begin
    lz = '0;
    for (int i = 0; i < W; i++) begin
      if (sum_reg[i]) lz = LZW'(W - 1 - i);
    end
    if (sum_reg[W]) begin
      norm_man = {sum_reg[W:2], sum_reg[1] | sum_reg[0]};
      norm_exp = exp_reg + XE'(1);
    end else begin
      norm_man = sum_reg[W-1:0] << lz;
      norm_exp = exp_reg - $signed({{(XE-LZW){1'b0}}, lz});
    end
  end

  logic                 round_up, grs;
  logic [M+1:0]         rnd;
  logic [M-1:0]         rnd_man;
  logic signed [XE-1:0] rnd_exp;
  always_comb begin
    grs = |man_reg[2:0];
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    round_up = man_reg[2] & (man_reg[1] | man_reg[0] | man_reg[3]);
`else
    round_up = 1'b0;
`endif
    rnd = {1'b0, man_reg[W-1:3]} + {{(M+1){1'b0}}, round_up};
    if (rnd[M+1]) begin
      rnd_man = rnd[M:1];
      rnd_exp = exp_reg + XE'(1);
    end else begin
      rnd_man = rnd[M-1:0];
      rnd_exp = exp_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (set) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      c         <= '0;
      c_exp     <= '0;
      c_sign    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: if (set) begin
          a_man_reg  <= a;
          b_man_reg  <= b;
          a_exp_reg  <= a_exp;
          b_exp_reg  <= b_exp;
          a_sign_reg <= a_sign;
          b_sign_reg <= b_sign ^ op;
          busy       <= 1'b1;
        end
        ALIGN: begin
          x_ext_reg   <= {1'b1, x_man, 3'b000};
          y_ext_reg   <= y_shift;
          sub_reg     <= x_sign ^ y_sign;
          sign_reg    <= x_sign;
          exp_reg     <= $signed({2'b00, x_exp});
          special_reg <= sp;
          sp_inv_reg  <= sp_inv;
          sp_sign_reg <= sp_sign;
          sp_exp_reg  <= sp_exp;
          sp_man_reg  <= sp_man;
        end
        ADD: sum_reg <= sum_next;
        NORM: begin
          man_reg  <= norm_man;
          exp_reg  <= norm_exp;
          zero_reg <= (sum_reg == '0);
          uf_reg   <= (norm_exp <= ZERO_X);
        end
        ROUND: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          inexact   <= 1'b0;
          invalid   <= 1'b0;
          if (special_reg) begin
            {c_sign, c_exp, c} <= {sp_sign_reg, sp_exp_reg, sp_man_reg};
            invalid <= sp_inv_reg;
          end else if (zero_reg) begin
            {c_sign, c_exp, c} <= '0;
          end else if (uf_reg) begin
            // Flushing a nonzero value always discards set bits
            {c_sign, c_exp, c} <= {sign_reg, {E{1'b0}}, {M{1'b0}}};
            underflow <= 1'b1;
            inexact   <= 1'b1;
          end else if (rnd_exp >= EMAX_X) begin
            overflow <= 1'b1;
            inexact  <= 1'b1;
            c_sign   <= sign_reg;
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
            c_exp <= EMAX;
            c     <= '0;
`else
            c_exp <= EMAX - E'(1);
            c     <= '1;
`endif
          end else begin
            c_sign  <= sign_reg;
            c_exp   <= rnd_exp[E-1:0];
            c       <= rnd_man;
            inexact <= grs;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// Bench for fp_addsub_unit: directed corner cases plus random operands against an exact-integer reference model.
`timescale 1ns/1ps
module tb_fp_addsub_unit;
  localparam int M = 10;
  localparam int E = 5;
  localparam int EMAX = (1 << E) - 1;

  logic         clk = 1'b0, reset = 1'b0, set = 1'b0, op = 1'b0;
  logic [M-1:0] a = '0, b = '0, c;
  logic [E-1:0] a_exp = '0, b_exp = '0, c_exp;
  logic         a_sign = 1'b0, b_sign = 1'b0, c_sign;
  logic         busy, done, overflow, underflow, inexact, invalid;

  fp_addsub_unit dut (
    .clk(clk), .reset(reset), .set(set), .op(op),
    .a(a), .b(b), .a_exp(a_exp), .b_exp(b_exp), .a_sign(a_sign), .b_sign(b_sign),
    .c(c), .c_exp(c_exp), .c_sign(c_sign), .busy(busy), .done(done),
    .overflow(overflow), .underflow(underflow), .inexact(inexact), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s; logic [E-1:0] e; logic [M-1:0] m;
    logic ovf; logic unf; logic inx; logic inv;
  } res_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact value of each operand as a scaled integer; sum, then normalise and round from scratch
  function automatic res_t ref_model(input logic [M-1:0] am, input logic [E-1:0] ae, input logic as_,
                                     input logic [M-1:0] bm, input logic [E-1:0] be, input logic bs0,
                                     input logic o);
    res_t r;
    logic bs, a_nan, b_nan, a_inf, b_inf;
    longint ia, ib, sum, mag, keep, rem, half;
    int p, ex;
    r = '0;
    bs = bs0 ^ o;
    a_nan = (int'(ae) == EMAX) && (am != 0);
    b_nan = (int'(be) == EMAX) && (bm != 0);
    a_inf = (int'(ae) == EMAX) && (am == 0);
    b_inf = (int'(be) == EMAX) && (bm == 0);
    if (a_nan || b_nan || (a_inf && b_inf && as_ != bs)) begin
      r.e = '1; r.m = {1'b1, {(M-1){1'b0}}}; r.inv = 1'b1;
      return r;
    end
    if (a_inf) begin r.s = as_; r.e = '1; return r; end
    if (b_inf) begin r.s = bs;  r.e = '1; return r; end
    if (ae == 0 && be == 0) begin r.s = as_ & bs; return r; end
    if (ae == 0) begin r.s = bs;  r.e = be; r.m = bm; return r; end
    if (be == 0) begin r.s = as_; r.e = ae; r.m = am; return r; end
    ia = longint'({1'b1, am}) << (int'(ae) - 1);
    ib = longint'({1'b1, bm}) << (int'(be) - 1);
    if (as_) ia = -ia;
    if (bs)  ib = -ib;
    sum = ia + ib;
    if (sum == 0) return r;
    r.s = (sum < 0);
    mag = (sum < 0) ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    ex = p + 1 - M;
    if (ex <= 0) begin r.unf = 1'b1; r.inx = 1'b1; return r; end
    if (p > M) begin
      keep = mag >> (p - M);
      rem  = mag - (keep << (p - M));
      half = longint'(1) << (p - M - 1);
      r.inx = (rem != 0);
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep == (longint'(1) << (M + 1))) begin keep = keep >> 1; ex = ex + 1; end
`endif
    end else begin
      keep = mag << (M - p);
    end
    if (ex >= EMAX) begin
      r.ovf = 1'b1; r.inx = 1'b1;
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
      r.e = '1; r.m = '0;
`else
      r.e = E'(EMAX - 1); r.m = '1;
`endif
    end else begin
      r.e = ex[E-1:0];
      r.m = keep[M-1:0];
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [M-1:0] am, input logic [E-1:0] ae, input logic as_,
                        input logic [M-1:0] bm, input logic [E-1:0] be, input logic bs, input logic o,
                        output res_t got);
    res_t r;
    int lat;
    r = ref_model(am, ae, as_, bm, be, bs, o);
    @(negedge clk);
    a = am; a_exp = ae; a_sign = as_; b = bm; b_exp = be; b_sign = bs; op = o; set = 1'b1;
    @(posedge clk); #1;
    set = 1'b0;
    check_val({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, ".latency"}, lat, 32'd4);
    got = {c_sign, c_exp, c, overflow, underflow, inexact, invalid};
    check_val({tag, ".result"}, 32'({got.s, got.e, got.m}), 32'({r.s, r.e, r.m}));
    check_val({tag, ".flags"}, 32'({got.ovf, got.unf, got.inx, got.inv}), 32'({r.ovf, r.unf, r.inx, r.inv}));
    $display("%s a=%b/%b/%b b=%b/%b/%b op=%b -> c=%b/%b/%b ovf=%b unf=%b inx=%b inv=%b",
             tag, as_, ae, am, bs, be, bm, o, c_sign, c_exp, c, overflow, underflow, inexact, invalid);
  endtask

  initial begin
    res_t g;
    int dones;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_val("reset.outputs", 32'({c_sign, c_exp, c, overflow, underflow, inexact, invalid, busy, done}), 32'd0);

    run_op("tp1", 10'b1011100111, 5'b10010, 1'b1, 10'b1011101001, 5'b10010, 1'b0, 1'b0, g);
    check_val("tp1.const", 32'({g.s, g.e, g.m, g.inx}), 32'({1'b0, 5'b01001, 10'd0, 1'b0}));
    run_op("tp2.add", 10'd0, 5'b01111, 1'b0, 10'd0, 5'b01111, 1'b0, 1'b0, g);
    check_val("tp2.add.const", 32'({g.s, g.e, g.m}), 32'({1'b0, 5'b10000, 10'd0}));
    run_op("tp2.sub", 10'd0, 5'b01111, 1'b0, 10'd0, 5'b01111, 1'b0, 1'b1, g);
    check_val("tp2.sub.const", 32'(g), 32'd0);
    run_op("tp3", 10'd1, 5'b01111, 1'b0, 10'd0, 5'b00100, 1'b0, 1'b0, g);
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    check_val("tp3.const", 32'({g.e, g.m, g.inx}), 32'({5'b01111, 10'd2, 1'b1}));
`else
    check_val("tp3.const", 32'({g.e, g.m, g.inx}), 32'({5'b01111, 10'd1, 1'b1}));
`endif
    run_op("tp4", 10'h3FF, 5'b11110, 1'b0, 10'h3FF, 5'b11110, 1'b0, 1'b0, g);
`ifdef FP_ADDSUB_ROUND_NEAREST_EN
    check_val("tp4.const", 32'({g.e, g.m, g.ovf}), 32'({5'b11111, 10'd0, 1'b1}));
`else
    check_val("tp4.const", 32'({g.e, g.m, g.ovf}), 32'({5'b11110, 10'h3FF, 1'b1}));
`endif
    run_op("tp5", 10'd0, 5'b11111, 1'b0, 10'd0, 5'b11111, 1'b0, 1'b1, g);
    check_val("tp5.const", 32'({g.e, g.m, g.inv}), 32'({5'b11111, 10'b1000000000, 1'b1}));
    run_op("underflow", 10'h155, 5'b00001, 1'b0, 10'h154, 5'b00001, 1'b0, 1'b1, g);
    check_val("underflow.const", 32'({g.e, g.m, g.unf}), 32'({5'd0, 10'd0, 1'b1}));

    for (int k = 0; k < 400; k++) begin
      int ea, eb, sel;
      logic [M-1:0] am, bm;
      sel = int'($urandom_range(0, 15));
      ea = (sel == 0) ? 0 : (sel == 1) ? EMAX : int'($urandom_range(1, EMAX - 1));
      sel = int'($urandom_range(0, 15));
      if (sel == 0) eb = 0;
      else if (sel == 1) eb = EMAX;
      else if (sel < 10) begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        if (eb < 1) eb = 1;
        if (eb > EMAX - 1) eb = EMAX - 1;
      end else eb = int'($urandom_range(1, EMAX - 1));
      am = M'($urandom);
      bm = (sel == 2) ? am : M'($urandom);
      if (ea == EMAX && $urandom_range(0, 1) == 0) am = '0;
      if (eb == EMAX && $urandom_range(0, 1) == 0) bm = '0;
      run_op("rnd", am, E'(ea), 1'($urandom), bm, E'(eb), 1'($urandom), 1'($urandom), g);
    end

    // Second set during the operation must be dropped
    @(negedge clk);
    a = '0; a_exp = 5'b01111; a_sign = 1'b0; b = '0; b_exp = 5'b01111; b_sign = 1'b0; op = 1'b0; set = 1'b1;
    @(posedge clk); #1;
    set = 1'b0;
    @(negedge clk);
    a_exp = 5'b10100; b_exp = 5'b10100; set = 1'b1;
    @(posedge clk); #1;
    set = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        check_val("busyset.result", 32'({c_sign, c_exp, c}), 32'({1'b0, 5'b10000, 10'd0}));
      end
    end
    check_val("busyset.dones", dones, 32'd1);

    // Reset asserted while the operation sits in NORM
    @(negedge clk);
    a = 10'h123; a_exp = 5'b10001; a_sign = 1'b1; b = 10'h0F0; b_exp = 5'b01110; b_sign = 1'b0; set = 1'b1;
    @(posedge clk); #1;
    set = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_val("midreset.outputs", 32'({c_sign, c_exp, c, overflow, underflow, inexact, invalid, busy, done}), 32'd0);
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check_val("midreset.nodone", dones, 32'd0);
    run_op("postreset", 10'h200, 5'b10000, 1'b0, 10'h100, 5'b01111, 1'b0, 1'b0, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
- Multi-cycle floating-point add/subtract unit for the GPU arithmetic path; parametrised successor of the first-generation FP adder.
- Operands and result keep separate mantissa, exponent and sign ports.
- Adds: subtract mode, round-to-nearest-even, IEEE-style special values, status flags, and a set/busy/done handshake.
- Fixed latency, one operation in flight.

Parameters:
- M, 10, stored mantissa width (fraction bits; hidden leading 1 implied).
- E, 5, exponent width; bias = 2^(E-1)-1.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- set  in  1  start request, sampled only in IDLE
- op  in  1  0 = a+b, 1 = a-b
- a, b  in  M  operand mantissas
- a_exp, b_exp  in  E  operand exponents
- a_sign, b_sign  in  1  operand signs
- c  out  M  result mantissa
- c_exp  out  E  result exponent
- c_sign  out  1  result sign
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- overflow, underflow, inexact, invalid  out  1 each  status flags, valid with done

Behaviour:
- Reset (reset low at a rising edge):
  - state goes to IDLE;
  - c, c_exp, c_sign, busy, done and all flags go to 0;
  - reset overrides everything, including mid-operation, and the in-flight result is discarded.
- Encoding:
  - exp = 0: zero (no denormals; denormal inputs are treated as zero);
  - exp = all-ones, mantissa 0: infinity;
  - exp = all-ones, mantissa nonzero: NaN.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE.
  - Edge N, IDLE with set=1: operands and op are registered; b_sign is inverted when op=1. busy=1 after this edge.
  - ALIGN: the smaller-magnitude operand is right-shifted by the exponent difference into M+3 bits (guard, round, sticky). A shift of M+3 or more leaves only sticky.
  - ADD: mantissas with hidden bit are added or subtracted on M+5 bits. The result sign is the sign of the larger magnitude.
  - NORM: single-cycle leading-zero count and shift, or a 1-bit right shift on carry-out; the exponent is adjusted.
  - ROUND: round-to-nearest-even on guard/round/sticky, with renormalisation if rounding carries out.
  - At edge N+4: c, c_exp, c_sign and the flags are registered; done=1 and busy=0 for exactly one cycle; state goes to IDLE.
- Latency: 4 cycles from the set-sampling edge to done. done drops at edge N+5. A new set may be sampled at edge N+5, so throughput is one operation per 5 cycles.
- set while busy: ignored, no queuing. Inputs are don't-care except in the IDLE set cycle.
- Special cases (resolved at ALIGN, still taking the full latency):
  - NaN operand, or inf minus inf: NaN result, exp all-ones, mantissa MSB=1, sign 0, invalid=1.
  - inf op finite: that infinity with its effective sign.
  - Either operand zero: the other operand is passed through unchanged, with its effective sign.
  - Exact cancellation: +0, all fields 0.
- Overflow: a biased exponent >= all-ones after rounding gives infinity with the correct sign; overflow=1 and inexact=1.
- Underflow: a biased exponent <= 0 after normalisation gives signed zero (flush); underflow=1, and inexact=1 if any nonzero bits were discarded.
- inexact=1 whenever any guard/round/sticky bit was nonzero.
- Flags hold their values until the next done or reset.

Optional Feature:
- Macro: FP_ADDSUB_ROUND_NEAREST_EN.
- Defined: ROUND stage performs round-to-nearest-even as specified.
- Undefined: ROUND truncates toward zero, so overflow saturates to the largest finite value instead of infinity. inexact is still computed from guard/round/sticky. Latency is unchanged (the ROUND state still exists).

Test Plan:
- a=1011100111, a_exp=10010, a_sign=1, b=1011101001, b_exp=10010, b_sign=0, op=0 -> c=0000000000, c_exp=01001, c_sign=0, inexact=0, done 4 cycles after set.
- a=0, a_exp=01111 (1.0), b=0, b_exp=01111, op=0 -> c_exp=10000, c=0 (2.0); same operands with op=1 -> all-zero +0.
- a=0000000001, a_exp=01111 (1+2^-10), b=0, b_exp=00100 (2^-11), op=0 -> with the macro: c=0000000010, c_exp=01111, inexact=1; without the macro: c=0000000001, inexact=1.
- a=b=1111111111, exp=11110 (65504), op=0 -> with the macro: c_exp=11111, c=0, overflow=1; without the macro: c_exp=11110, c=1111111111, overflow=1.
- a=b=infinity (exp=11111, mantissa 0), both sign 0, op=1 -> c_exp=11111, c=1000000000, invalid=1.
- Second set pulsed while busy is ignored, with exactly one done. reset driven low in NORM -> next cycle busy=0, done=0, all outputs 0, no done follows. A new set after reset is released completes normally.
